// File: rtl/sr_flipflop.sv
// ----------------------------------------------------------------------------
// sr_flipflop
//   Clocked set/reset storage element, WIDTH independent bits. S and R are
//   sampled on each rising clk edge. The S=R=1 case is resolved by
//   BOTH_POLICY and flagged on err for one cycle.
//
// Parameters
//   WIDTH        number of independent SR bits
//   RESET_VALUE  value loaded into Q on reset
//   BOTH_POLICY  S=R=1 action: 0 hold, 1 set wins, 2 reset wins, 3 toggle;
//                any other value behaves as hold
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-high reset
//   S     in   WIDTH  set request
//   R     in   WIDTH  reset request
//   Q     out  WIDTH  stored state (registered)
//   Qn    out  WIDTH  ~Q, combinational from the same storage
//   err   out  WIDTH  registered S&R of the last sampled edge
// ----------------------------------------------------------------------------
module sr_flipflop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      BOTH_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] err
);

    typedef enum logic [1:0] {
        POL_HOLD   = 2'd0,
        POL_SET    = 2'd1,
        POL_RESET  = 2'd2,
        POL_TOGGLE = 2'd3
    } both_pol_e;

    // Out-of-range policy values collapse to hold.
    localparam both_pol_e POLICY = (BOTH_POLICY <= 32'd3) ?
                                   both_pol_e'(2'(BOTH_POLICY)) : POL_HOLD;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] err_q;
    logic [WIDTH-1:0] err_d;
    logic [WIDTH-1:0] set_only;
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] both_val;

    // Next-state: hold where neither request is active, set where only S,
    // clear falls out of the hold/set terms, policy value where both.
    always_comb begin
        set_only = S & ~R;
        both     = S & R;
        both_val = q_q;
        case (POLICY)
            POL_SET:    both_val = '1;
            POL_RESET:  both_val = '0;
            POL_TOGGLE: both_val = ~q_q;
            default:    both_val = q_q;
        endcase
        q_d   = (q_q & ~(S | R)) | set_only | (both & both_val);
        err_d = both;
    end

    // State register; reset takes effect without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= RESET_VALUE;
            err_q <= '0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign Q   = q_q;
    assign Qn  = ~q_q;
    assign err = err_q;

endmodule

// File: tb/tb_sr_flipflop.sv
// Bench for sr_flipflop: one WIDTH=1 default instance plus WIDTH=4 instances
// for every BOTH_POLICY (including an out-of-range one). Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_sr_flipflop;

    localparam logic [3:0] RV4 = 4'b0011;

    logic       clk = 1'b0;
    logic       rst;
    logic       S1, R1;
    logic       Q1, Qn1, err1;
    logic [3:0] S4, R4;
    logic [3:0] q4  [5];
    logic [3:0] qn4 [5];
    logic [3:0] e4  [5];

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic            q1;
        logic            e1;
        logic [4:0][3:0] q4;
        logic [3:0]      e4;
    } exp_t;

    exp_t       sb[$];
    logic       m1;
    logic [3:0] m4 [5];

    always #5 clk = ~clk;

    sr_flipflop u_d1 (.clk(clk), .rst(rst), .S(S1), .R(R1), .Q(Q1), .Qn(Qn1), .err(err1));

    sr_flipflop #(.WIDTH(4), .RESET_VALUE(RV4), .BOTH_POLICY(0)) u_p0
        (.clk(clk), .rst(rst), .S(S4), .R(R4), .Q(q4[0]), .Qn(qn4[0]), .err(e4[0]));
    sr_flipflop #(.WIDTH(4), .RESET_VALUE(RV4), .BOTH_POLICY(1)) u_p1
        (.clk(clk), .rst(rst), .S(S4), .R(R4), .Q(q4[1]), .Qn(qn4[1]), .err(e4[1]));
    sr_flipflop #(.WIDTH(4), .RESET_VALUE(RV4), .BOTH_POLICY(2)) u_p2
        (.clk(clk), .rst(rst), .S(S4), .R(R4), .Q(q4[2]), .Qn(qn4[2]), .err(e4[2]));
    sr_flipflop #(.WIDTH(4), .RESET_VALUE(RV4), .BOTH_POLICY(3)) u_p3
        (.clk(clk), .rst(rst), .S(S4), .R(R4), .Q(q4[3]), .Qn(qn4[3]), .err(e4[3]));
    sr_flipflop #(.WIDTH(4), .RESET_VALUE(RV4), .BOTH_POLICY(7)) u_p7
        (.clk(clk), .rst(rst), .S(S4), .R(R4), .Q(q4[4]), .Qn(qn4[4]), .err(e4[4]));

    function automatic int pol_of(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 7;
        endcase
    endfunction

    // Per-bit SR truth table.
    function automatic logic [3:0] model(input logic [3:0] q, input logic [3:0] s,
                                         input logic [3:0] r, input int pol);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            if (s[i] && !r[i])       n[i] = 1'b1;
            else if (!s[i] && r[i])  n[i] = 1'b0;
            else if (s[i] && r[i]) begin
                case (pol)
                    1:       n[i] = 1'b1;
                    2:       n[i] = 1'b0;
                    3:       n[i] = ~q[i];
                    default: n[i] = q[i];
                endcase
            end else                 n[i] = q[i];
        end
        return n;
    endfunction

    // Apply inputs and push the expected post-edge outputs.
    task automatic drive(input logic s1, input logic r1, input logic [3:0] s4, input logic [3:0] r4);
        exp_t       e;
        logic [3:0] t;
        S1 = s1; R1 = r1; S4 = s4; R4 = r4;
        t  = model({3'b000, m1}, {3'b000, s1}, {3'b000, r1}, 0);
        m1 = t[0];
        for (int k = 0; k < 5; k++) begin
            m4[k]   = model(m4[k], s4, r4, pol_of(k));
            e.q4[k] = m4[k];
        end
        e.q1 = m1;
        e.e1 = s1 & r1;
        e.e4 = s4 & r4;
        sb.push_back(e);
    endtask

    task automatic reset_models();
        m1 = 1'b0;
        for (int k = 0; k < 5; k++) m4[k] = RV4;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; S1 = 1'b1; R1 = 1'b0; S4 = 4'b1111; R4 = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) #1; else begin @(posedge clk); #1; end
            total_cnt++; if (Q1 !== 1'b0)   $display("FAIL rst_q[%0d]: got %b want 0", n, Q1);   else pass_cnt++;
            total_cnt++; if (Qn1 !== 1'b1)  $display("FAIL rst_qn[%0d]: got %b want 1", n, Qn1); else pass_cnt++;
            total_cnt++; if (err1 !== 1'b0) $display("FAIL rst_err[%0d]: got %b want 0", n, err1); else pass_cnt++;
            total_cnt++; if (q4[1] !== RV4) $display("FAIL rst_q4[%0d]: got %b want %b", n, q4[1], RV4); else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        reset_models();
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++; if (Q1 !== 1'b1)  $display("FAIL rel_q: got %b want 1", Q1);  else pass_cnt++;
        total_cnt++; if (Qn1 !== 1'b0) $display("FAIL rel_qn: got %b want 0", Qn1); else pass_cnt++;
        total_cnt++; if (Q1 !== e.q1)  $display("FAIL rel_q_sb: got %b want %b", Q1, e.q1); else pass_cnt++;
    endtask

    task automatic test_set_reset_hold();
        logic [1:0] vec [4] = '{2'b01, 2'b10, 2'b00, 2'b10};
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive(vec[n][1], vec[n][0], 4'b0000, 4'b0000);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                total_cnt++; $display("FAIL srh_sb[%0d]: got empty want entry", n);
            end else begin
                e = sb.pop_front();
                total_cnt++; if (Q1 !== e.q1)   $display("FAIL srh_q[%0d]: got %b want %b", n, Q1, e.q1);    else pass_cnt++;
                total_cnt++; if (Qn1 !== ~e.q1) $display("FAIL srh_qn[%0d]: got %b want %b", n, Qn1, ~e.q1); else pass_cnt++;
                total_cnt++; if (err1 !== e.e1) $display("FAIL srh_err[%0d]: got %b want %b", n, err1, e.e1); else pass_cnt++;
            end
        end
    endtask

    task automatic test_invalid_default();
        logic [1:0] vec [3] = '{2'b10, 2'b11, 2'b00};
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            drive(vec[n][1], vec[n][0], 4'b0000, 4'b0000);
            @(posedge clk); #1;
            e = sb.pop_front();
            total_cnt++; if (Q1 !== e.q1)   $display("FAIL inv_q[%0d]: got %b want %b", n, Q1, e.q1);    else pass_cnt++;
            total_cnt++; if (Qn1 !== ~e.q1) $display("FAIL inv_qn[%0d]: got %b want %b", n, Qn1, ~e.q1); else pass_cnt++;
            total_cnt++; if (err1 !== e.e1) $display("FAIL inv_err[%0d]: got %b want %b", n, err1, e.e1); else pass_cnt++;
        end
    endtask

    task automatic test_policies();
        logic [3:0] vs [4] = '{4'b0101, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] vr [4] = '{4'b1010, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] first_both [5] = '{4'b0101, 4'b1111, 4'b0000, 4'b1010, 4'b0101};
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, vs[n], vr[n]);
            @(posedge clk); #1;
            e = sb.pop_front();
            for (int k = 0; k < 5; k++) begin
                total_cnt++; if (q4[k] !== e.q4[k])   $display("FAIL pol%0d_q[%0d]: got %b want %b", pol_of(k), n, q4[k], e.q4[k]);    else pass_cnt++;
                total_cnt++; if (qn4[k] !== ~e.q4[k]) $display("FAIL pol%0d_qn[%0d]: got %b want %b", pol_of(k), n, qn4[k], ~e.q4[k]); else pass_cnt++;
                total_cnt++; if (e4[k] !== e.e4)      $display("FAIL pol%0d_err[%0d]: got %b want %b", pol_of(k), n, e4[k], e.e4);     else pass_cnt++;
                if (n == 1) begin
                    total_cnt++; if (q4[k] !== first_both[k]) $display("FAIL pol%0d_both1: got %b want %b", pol_of(k), q4[k], first_both[k]); else pass_cnt++;
                    total_cnt++; if (e4[k] !== 4'b1111)       $display("FAIL pol%0d_err1: got %b want 1111", pol_of(k), e4[k]); else pass_cnt++;
                end
            end
            if (n == 2) begin
                total_cnt++; if (q4[3] !== 4'b0101) $display("FAIL toggle_back: got %b want 0101", q4[3]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b1111, 4'b0000);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++; if (Q1 !== e.q1)       $display("FAIL ar_pre_q: got %b want %b", Q1, e.q1); else pass_cnt++;
        total_cnt++; if (q4[2] !== e.q4[2]) $display("FAIL ar_pre_q4: got %b want %b", q4[2], e.q4[2]); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (Q1 !== 1'b0)   $display("FAIL ar_mid_q: got %b want 0", Q1);   else pass_cnt++;
        total_cnt++; if (Qn1 !== 1'b1)  $display("FAIL ar_mid_qn: got %b want 1", Qn1); else pass_cnt++;
        total_cnt++; if (q4[0] !== RV4) $display("FAIL ar_mid_q4: got %b want %b", q4[0], RV4); else pass_cnt++;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            total_cnt++; if (Q1 !== 1'b0)   $display("FAIL ar_hold_q[%0d]: got %b want 0", n, Q1);   else pass_cnt++;
            total_cnt++; if (err1 !== 1'b0) $display("FAIL ar_hold_err[%0d]: got %b want 0", n, err1); else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        reset_models();
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++; if (Q1 !== e.q1)       $display("FAIL ar_rel_q: got %b want %b", Q1, e.q1); else pass_cnt++;
        total_cnt++; if (q4[3] !== e.q4[3]) $display("FAIL ar_rel_q4: got %b want %b", q4[3], e.q4[3]); else pass_cnt++;
    endtask

    task automatic test_glitch();
        exp_t e;
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++; if (Q1 !== e.q1) $display("FAIL gl_pre_q: got %b want %b", Q1, e.q1); else pass_cnt++;
        #1;
        S1 = 1'b1; S4 = 4'b1111;
        #2;
        S1 = 1'b0; S4 = 4'b0000;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++; if (Q1 !== e.q1)   $display("FAIL gl_q: got %b want %b", Q1, e.q1);   else pass_cnt++;
        total_cnt++; if (Q1 !== 1'b0)   $display("FAIL gl_q0: got %b want 0", Q1);        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++; if (q4[k] !== RV4) $display("FAIL gl_q4[%0d]: got %b want %b", k, q4[k], RV4); else pass_cnt++;
        end
    endtask

    initial begin
        reset_models();
        test_reset();
        test_set_reset_hold();
        test_invalid_default();
        test_policies();
        test_async_reset();
        test_glitch();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d want 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
